// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address and picks the next PC from
// sequential, branch, jump, jump-register, external load or exception sources.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              exception,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              misaligned,
  output logic              valid,
  output logic [CNT_W-1:0]  exc_count
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VECTOR);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              misaligned_q, misaligned_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  exc_count_q, exc_count_d;

  logic [ADDR_W-1:0] br_offset_ext;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jt_target;
  logic              fault;

  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign br_offset_ext = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign br_target     = pc_plus4 + br_offset_ext;
  assign jt_target     = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};

  // A misaligned register jump outranks both stall and pc_load.
  assign fault = jump_reg && (reg_target[1:0] != 2'b00);

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = misaligned_q;
    valid_d      = 1'b0;
    exc_count_d  = exc_count_q;
    if (exception || fault) begin
      pc_d         = EXC_PC;
      epc_d        = pc_q;
      misaligned_d = fault && !exception;
      valid_d      = 1'b1;
      if (exc_count_q != CNT_MAX) exc_count_d = exc_count_q + CNT_W'(1);
    end else if (!stall) begin
      valid_d = 1'b1;
      if (pc_load)           pc_d = pc_in;
      else if (jump_reg)     pc_d = reg_target;
      else if (jump)         pc_d = jt_target;
      else if (branch_taken) pc_d = br_target;
      else                   pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      valid_q      <= 1'b0;
      exc_count_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      valid_q      <= valid_d;
      exc_count_q  <= exc_count_d;
    end
  end

  assign pc_out     = pc_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;
  assign valid      = valid_q;
  assign exc_count  = exc_count_q;

endmodule
